// File: rtl/i2s_tx.sv
// I2S transmitter: rescales and saturates a wide filter result to a 24-bit sample
// and sends it on both channels of a 64-bit-per-frame I2S stream with a locally divided bit clock.
module i2s_tx #(
    parameter int IN_W       = 34,
    parameter int OUT_W      = 24,
    parameter int FRAC_SHIFT = 8,
    parameter int BCLK_DIV   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IN_W-1:0] result_i,
    input  logic            done_i,
    input  logic            clr_flags_i,
    output logic            bclk_o,
    output logic            lrclk_o,
    output logic            sdata_o,
    output logic            hold_full_o,
    output logic            underrun_o,
    output logic            overrun_o
);

    localparam int DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic signed [IN_W-1:0] SAT_HI = IN_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [IN_W-1:0] SAT_LO = IN_W'(-(64'sd1 <<< (OUT_W - 1)));
    localparam logic [4:0] LAST_P = 5'(OUT_W);

    logic signed [IN_W-1:0] shifted;
    logic [OUT_W-1:0]       sample;
    logic [DIV_W-1:0]       div_cnt;
    logic [5:0]             bit_cnt;
    logic [5:0]             next_bit;
    logic [4:0]             next_p;
    logic [OUT_W-1:0]       tx_sample;
    logic [OUT_W-1:0]       holding;
    logic [OUT_W-1:0]       slot_word;
    logic                   data_bit;
    logic                   tick;
    logic                   fall;
    logic                   frame_load;
    logic                   set_underrun;
    logic                   set_overrun;

    assign shifted = $signed(result_i) >>> FRAC_SHIFT;

    always_comb begin
        if (shifted > SAT_HI) begin
            sample = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (shifted < SAT_LO) begin
            sample = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            sample = shifted[OUT_W-1:0];
        end
    end

    assign tick       = (div_cnt == DIV_LAST);
    assign fall       = tick & bclk_o;
    assign frame_load = fall & (bit_cnt == 6'd63);
    assign next_bit   = bit_cnt + 6'd1;
    assign next_p     = next_bit[4:0];

    // Slot position p carries sample bit OUT_W-p; shifting left by p-1 puts it at the MSB.
    assign slot_word = tx_sample << (next_p - 5'd1);
    assign data_bit  = (next_p != 5'd0) && (next_p <= LAST_P) ? slot_word[OUT_W-1] : 1'b0;

    assign set_underrun = frame_load & ~hold_full_o;
    assign set_overrun  = done_i & hold_full_o & ~frame_load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            bclk_o  <= 1'b0;
        end else if (tick) begin
            div_cnt <= '0;
            bclk_o  <= ~bclk_o;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Serial outputs move only on bclk falling edges so they are settled at each rise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt <= 6'd63;
            lrclk_o <= 1'b0;
            sdata_o <= 1'b0;
        end else if (fall) begin
            bit_cnt <= next_bit;
            lrclk_o <= next_bit[5];
            sdata_o <= data_bit;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_sample   <= '0;
            holding     <= '0;
            hold_full_o <= 1'b0;
        end else begin
            if (frame_load && hold_full_o) begin
                tx_sample <= holding;
            end
            if (done_i) begin
                holding     <= sample;
                hold_full_o <= 1'b1;
            end else if (frame_load) begin
                hold_full_o <= 1'b0;
            end
        end
    end

    // A flag being set in the same cycle as a clear request stays set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            underrun_o <= 1'b0;
            overrun_o  <= 1'b0;
        end else begin
            if (set_underrun) begin
                underrun_o <= 1'b1;
            end else if (clr_flags_i) begin
                underrun_o <= 1'b0;
            end
            if (set_overrun) begin
                overrun_o <= 1'b1;
            end else if (clr_flags_i) begin
                overrun_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: a slot monitor decodes the serial stream and
// compares each slot against a queue of expected frame samples.
module tb_i2s_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [33:0] result_i = '0;
    logic        done_i = 1'b0;
    logic        clr_flags_i = 1'b0;
    logic        bclk_o;
    logic        lrclk_o;
    logic        sdata_o;
    logic        hold_full_o;
    logic        underrun_o;
    logic        overrun_o;

    int          checks_total = 0;
    int          checks_passed = 0;
    int          edge_no;
    logic [23:0] sb[$];

    int          mon_cnt;
    logic        prev_bclk;
    logic        prev_lr;
    int          last_toggle;
    logic [23:0] word;
    logic        pad;
    int          lr_err;

    i2s_tx #(
        .IN_W(34),
        .OUT_W(24),
        .FRAC_SHIFT(8),
        .BCLK_DIV(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .result_i(result_i),
        .done_i(done_i),
        .clr_flags_i(clr_flags_i),
        .bclk_o(bclk_o),
        .lrclk_o(lrclk_o),
        .sdata_o(sdata_o),
        .hold_full_o(hold_full_o),
        .underrun_o(underrun_o),
        .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    // Edge numbering restarts at reset release; edge 1 is the first rising edge after it.
    always @(posedge clk or negedge reset) begin
        if (!reset) edge_no <= 0;
        else        edge_no <= edge_no + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end else begin
            checks_passed++;
        end
    endtask

    task automatic waitEdge(input int e);
        while (edge_no < e) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [33:0] value, input int e);
        waitEdge(e - 1);
        result_i = value;
        done_i   = 1'b1;
        waitEdge(e);
        done_i   = 1'b0;
    endtask

    task automatic pulseClear(input int e);
        waitEdge(e - 1);
        clr_flags_i = 1'b1;
        waitEdge(e);
        clr_flags_i = 1'b0;
    endtask

    // Slot monitor: samples at each bclk rise, skipping the single pre-frame bit after reset.
    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            mon_cnt     = -1;
            prev_bclk   = 1'b0;
            prev_lr     = 1'b0;
            last_toggle = -1;
            word        = '0;
            pad         = 1'b0;
            lr_err      = 0;
        end else begin
            if (bclk_o && !prev_bclk) begin
                if (mon_cnt >= 0) begin
                    int p;
                    p = mon_cnt % 32;
                    if (p == 0) begin
                        word   = '0;
                        pad    = sdata_o;
                        lr_err = 0;
                    end else if (p <= 24) begin
                        word = {word[22:0], sdata_o};
                    end else begin
                        pad = pad | sdata_o;
                    end
                    if (lrclk_o !== (mon_cnt >= 32)) lr_err++;
                    if (p == 31) begin
                        checkOutput("slot_pad", {31'd0, pad}, 32'd0);
                        checkOutput("slot_lrclk", lr_err, 32'd0);
                        if (sb.size() == 0) begin
                            checkOutput("sb_underflow", 32'd1, 32'd0);
                        end else if (mon_cnt < 32) begin
                            checkOutput("left_slot", {8'd0, word}, {8'd0, sb[0]});
                        end else begin
                            checkOutput("right_slot", {8'd0, word}, {8'd0, sb.pop_front()});
                        end
                    end
                end
                mon_cnt = (mon_cnt + 1) % 64;
            end
            prev_bclk = bclk_o;
            if (lrclk_o !== prev_lr) begin
                if (last_toggle >= 0) checkOutput("lr_period", edge_no - last_toggle, 32'd256);
                last_toggle = edge_no;
            end
            prev_lr = lrclk_o;
        end
    end

    initial begin
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_state", {26'd0, bclk_o, lrclk_o, sdata_o, hold_full_o, underrun_o, overrun_o}, 32'd0);
        reset = 1'b1;

        sb.push_back(24'h000001);
        applyStimulus(34'h0_0000_0100, 2);
        checkOutput("hold_set", hold_full_o, 1);
        waitEdge(3);
        checkOutput("bclk_e3", bclk_o, 0);
        waitEdge(4);
        checkOutput("bclk_e4", bclk_o, 1);
        waitEdge(7);
        checkOutput("bclk_e7", bclk_o, 1);
        waitEdge(8);
        checkOutput("bclk_e8", bclk_o, 0);
        checkOutput("lrclk_e8", lrclk_o, 0);
        checkOutput("hold_load", hold_full_o, 0);
        checkOutput("no_underrun", underrun_o, 0);

        sb.push_back(24'h7FFFFF);
        applyStimulus(34'h1_0000_0000, 100);
        sb.push_back(24'h800000);
        applyStimulus(34'h2_0000_0000, 600);
        sb.push_back(24'hFFFFFF);
        applyStimulus(34'h3_FFFF_FF00, 1100);

        sb.push_back(24'h000003);
        sb.push_back(24'h000003);
        applyStimulus(34'h0_0000_0300, 1600);
        waitEdge(2567);
        checkOutput("underrun_pre", underrun_o, 0);
        waitEdge(2568);
        checkOutput("underrun_set", underrun_o, 1);
        checkOutput("hold_empty", hold_full_o, 0);
        pulseClear(2700);
        checkOutput("underrun_clr", underrun_o, 0);

        sb.push_back(24'h000002);
        applyStimulus(34'h0_0000_0100, 2800);
        checkOutput("overrun_pre", overrun_o, 0);
        applyStimulus(34'h0_0000_0200, 2900);
        checkOutput("overrun_set", overrun_o, 1);
        checkOutput("hold_over", hold_full_o, 1);
        pulseClear(3100);
        checkOutput("overrun_clr", overrun_o, 0);

        sb.push_back(24'h000005);
        sb.push_back(24'h000007);
        applyStimulus(34'h0_0000_0500, 3200);
        checkOutput("hold_five", hold_full_o, 1);
        applyStimulus(34'h0_0000_0700, 3592);
        checkOutput("hold_simul", hold_full_o, 1);
        checkOutput("overrun_simul", overrun_o, 0);
        waitEdge(4104);
        checkOutput("hold_after7", hold_full_o, 0);
        checkOutput("underrun_none", underrun_o, 0);

        sb.push_back(24'h000007);
        pulseClear(4616);
        checkOutput("set_wins", underrun_o, 1);

        waitEdge(4940);
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        checkOutput("reset_mid", {26'd0, bclk_o, lrclk_o, sdata_o, hold_full_o, underrun_o, overrun_o}, 32'd0);
        reset = 1'b1;

        sb.push_back(24'h000000);
        waitEdge(7);
        checkOutput("rst_bclk_e7", bclk_o, 1);
        waitEdge(8);
        checkOutput("rst_bclk_e8", bclk_o, 0);
        checkOutput("rst_lrclk_e8", lrclk_o, 0);
        checkOutput("rst_underrun", underrun_o, 1);
        waitEdge(540);
        checkOutput("sb_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

endmodule
